// File: rtl/complex_fifo_pkg.sv
// Shared definitions for the complex I/Q FIFO write-side logic.
package complex_fifo_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam int unsigned CH_SUBGHZ = 0;
  localparam int unsigned CH_24G    = 1;

  function automatic int unsigned sample_width(input int unsigned data_width);
    return 2 * data_width;
  endfunction

endpackage

// File: rtl/complex_fifo_wr_arbiter_sat_counter.sv
// Saturating up-counter with asynchronous reset; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/complex_fifo_wr_arbiter.sv
// Round-robin, burst-granular arbiter sharing the complex FIFO write port
// between the sub-GHz (ch0) and 2.4 GHz (ch1) modem sample streams.
module complex_fifo_wr_arbiter
  import complex_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned BURST_LEN    = 64,
  parameter int unsigned IDLE_TIMEOUT = 8,
  parameter int unsigned DROP_ON_FULL = 0,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  en_i,
  input  logic                                  s0_valid_i,
  input  logic [sample_width(DATA_WIDTH)-1:0]   s0_data_i,
  output logic                                  s0_ready_o,
  input  logic                                  s1_valid_i,
  input  logic [sample_width(DATA_WIDTH)-1:0]   s1_data_i,
  output logic                                  s1_ready_o,
  input  logic                                  fifo_full_i,
  output logic                                  fifo_wr_en_o,
  output logic [sample_width(DATA_WIDTH)-1:0]   fifo_wr_data_o,
  output logic [1:0]                            grant_o,
  output logic                                  burst_done_o,
  output logic [CNT_WIDTH-1:0]                  drop_cnt0_o,
  output logic [CNT_WIDTH-1:0]                  drop_cnt1_o
);

  localparam int unsigned BW = $clog2(BURST_LEN + 1);
  localparam int unsigned TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(IDLE_TIMEOUT - 1);
  localparam logic          DROP       = (DROP_ON_FULL != 0);

  state_e          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            last_q, last_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            done_q, done_d;

  logic            g_valid, hs, pick_ch1;

  // Readies derive from the registered grant, so reset clears them immediately.
  assign s0_ready_o = grant_q[CH_SUBGHZ] & (DROP | ~fifo_full_i);
  assign s1_ready_o = grant_q[CH_24G]    & (DROP | ~fifo_full_i);

  assign g_valid = (grant_q[CH_SUBGHZ] & s0_valid_i) | (grant_q[CH_24G] & s1_valid_i);
  assign hs      = (s0_valid_i & s0_ready_o) | (s1_valid_i & s1_ready_o);

  assign fifo_wr_en_o   = hs & ~fifo_full_i;
  assign fifo_wr_data_o = grant_q[CH_24G]    ? s1_data_i :
                          grant_q[CH_SUBGHZ] ? s0_data_i : '0;

  // last_q = 1 means ch1 was served last, so ch0 is preferred next.
  assign pick_ch1 = last_q ? ~s0_valid_i : s1_valid_i;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    tcnt_d  = tcnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en_i && (s0_valid_i || s1_valid_i)) begin
          state_d = ST_BURST;
          grant_d = pick_ch1 ? 2'b10 : 2'b01;
          bcnt_d  = '0;
          tcnt_d  = '0;
        end
      end
      ST_BURST: begin
        if (hs) begin
          bcnt_d = bcnt_q + 1'b1;
          tcnt_d = '0;
        end else if (g_valid) begin
          tcnt_d = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
        if (!en_i || (hs && (bcnt_q == BURST_LAST)) || (!g_valid && (tcnt_q == TO_LAST))) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = grant_q[CH_24G];
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= 1'b1;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
      done_q  <= done_d;
    end
  end

  assign grant_o      = grant_q;
  assign burst_done_o = done_q;

  sat_counter #(.W(CNT_WIDTH)) u_drop0 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (hs & grant_q[CH_SUBGHZ] & fifo_full_i),
    .cnt_o (drop_cnt0_o)
  );

  sat_counter #(.W(CNT_WIDTH)) u_drop1 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (hs & grant_q[CH_24G] & fifo_full_i),
    .cnt_o (drop_cnt1_o)
  );

endmodule
